// File: rtl/decoder_nto2n_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : decoder_nto2n_seq_if
// Description : Request/select bundle for decoder_nto2n_seq.
//               master drives the request (iValid, iIn, iClr);
//               slave returns oReady and the registered select
//               (oOut, oIdx, oActive).
// Revision    : 1.0 - initial release
// ============================================================================
interface decoder_nto2n_seq_if #(
  parameter int N = 3
) ();
  logic              iValid;
  logic [N-1:0]      iIn;
  logic              iClr;
  logic              oReady;
  logic [2**N-1:0]   oOut;
  logic [N-1:0]      oIdx;
  logic              oActive;

  modport master (
    output iValid, iIn, iClr,
    input  oReady, oOut, oIdx, oActive
  );

  modport slave (
    input  iValid, iIn, iClr,
    output oReady, oOut, oIdx, oActive
  );
endinterface
`default_nettype wire

// File: rtl/decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module      : decoder_nto2n_seq
// Description : Registered binary-to-one-hot decoder with valid/ready
//               handshake. MODE=0 latches the decoded line until replaced or
//               cleared; MODE=1 drives it for PULSE_LEN cycles then releases.
// Ports       : iClk    - clock, rising edge
//               iRst    - synchronous active-high reset
//               bus     - slave side of decoder_nto2n_seq_if
//                         (iValid/iIn/iClr in; oReady/oOut/oIdx/oActive out)
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_nto2n_seq #(
  parameter int N          = 3,
  parameter int MODE       = 0,
  parameter int PULSE_LEN  = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 iClk,
  input  logic                 iRst,
  decoder_nto2n_seq_if.slave   bus
);

  localparam int              W        = 2**N;
  // Output value when nothing is selected; XOR with a one-hot word gives
  // the correctly polarised select.
  localparam logic [W-1:0]    IDLE_OUT = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [7:0]      CNT_LOAD = 8'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q,    cnt_d;
  logic [N-1:0]    idx_q,    idx_d;
  logic [W-1:0]    out_q,    out_d;
  logic            active_q, active_d;

  logic            ready;
  logic            accept;

  // Reset and clear both block acceptance so the edge priority
  // iRst > iClr > accept is visible on the handshake itself.
  assign ready  = !iRst && !bus.iClr && (state_q != S_ACTIVE);
  assign accept = bus.iValid && ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    out_d    = out_q;
    active_d = active_q;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (bus.iClr) begin
          state_d  = S_IDLE;
          out_d    = IDLE_OUT;
          active_d = 1'b0;
        end else if (accept) begin
          // A new accept in HOLD simply replaces the selection.
          state_d  = (MODE != 0) ? S_ACTIVE : S_HOLD;
          cnt_d    = (MODE != 0) ? CNT_LOAD : 8'd0;
          idx_d    = bus.iIn;
          out_d    = (W'(1) << bus.iIn) ^ IDLE_OUT;
          active_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (bus.iClr || (cnt_q == 8'd0)) begin
          // Abort or natural end of pulse; remaining count is discarded.
          state_d  = S_IDLE;
          cnt_d    = 8'd0;
          out_d    = IDLE_OUT;
          active_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = 8'd0;
        out_d    = IDLE_OUT;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      out_q    <= IDLE_OUT;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      active_q <= active_d;
    end
  end

  assign bus.oReady  = ready;
  assign bus.oOut    = out_q;
  assign bus.oIdx    = idx_q;
  assign bus.oActive = active_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_nto2n_seq
// Description : Self-checking bench for decoder_nto2n_seq. Five instances
//               cover latch mode, pulse lengths 4/1/10 and active-low output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_nto2n_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2, rst3, rst4;

  decoder_nto2n_seq_if #(.N(3)) b0 ();
  decoder_nto2n_seq_if #(.N(3)) b1 ();
  decoder_nto2n_seq_if #(.N(3)) b2 ();
  decoder_nto2n_seq_if #(.N(3)) b3 ();
  decoder_nto2n_seq_if #(.N(2)) b4 ();

  decoder_nto2n_seq #(.N(3), .MODE(0), .PULSE_LEN(1),  .ACTIVE_LOW(0)) d0 (.iClk(clk), .iRst(rst0), .bus(b0));
  decoder_nto2n_seq #(.N(3), .MODE(1), .PULSE_LEN(4),  .ACTIVE_LOW(0)) d1 (.iClk(clk), .iRst(rst1), .bus(b1));
  decoder_nto2n_seq #(.N(3), .MODE(1), .PULSE_LEN(1),  .ACTIVE_LOW(0)) d2 (.iClk(clk), .iRst(rst2), .bus(b2));
  decoder_nto2n_seq #(.N(3), .MODE(1), .PULSE_LEN(10), .ACTIVE_LOW(0)) d3 (.iClk(clk), .iRst(rst3), .bus(b3));
  decoder_nto2n_seq #(.N(2), .MODE(0), .PULSE_LEN(1),  .ACTIVE_LOW(1)) d4 (.iClk(clk), .iRst(rst4), .bus(b4));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Latch-mode vectors for d0: inputs before the edge, oReady seen with those
  // inputs, then outputs expected after the edge.
  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] in;
    logic       clr;
    logic       exp_rdy;
    logic [7:0] exp_out;
    logic [2:0] exp_idx;
    logic       exp_act;
  } vec_t;

  vec_t vecs[12];

  // Reference model for the random phase (index 0 = d0 latch, 1 = d1 pulse 4):
  // a selection is live with 'rem' cycles of visibility left.
  bit  m_act[2];
  int  m_idx[2];
  int  m_rem[2];
  int  m_len[2];

  initial begin
    logic [7:0] pat[11];
    logic r, cl, v;
    logic [2:0] x;
    logic [7:0] o[2];
    logic [2:0] ix[2];
    logic a[2], rd[2], acc[2];

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    b0.iValid = 0; b0.iIn = '0; b0.iClr = 0;
    b1.iValid = 0; b1.iIn = '0; b1.iClr = 0;
    b2.iValid = 0; b2.iIn = '0; b2.iClr = 0;
    b3.iValid = 0; b3.iIn = '0; b3.iClr = 0;
    b4.iValid = 0; b4.iIn = '0; b4.iClr = 0;

    //           rst valid in  clr rdy  out    idx act
    vecs[0]  = '{1, 0, 3'd0, 0, 0, 8'h00, 3'd0, 0};
    vecs[1]  = '{0, 1, 3'd5, 0, 1, 8'h20, 3'd5, 1};
    vecs[2]  = '{0, 0, 3'd2, 0, 1, 8'h20, 3'd5, 1};
    vecs[3]  = '{0, 0, 3'd4, 0, 1, 8'h20, 3'd5, 1};
    vecs[4]  = '{0, 0, 3'd0, 1, 0, 8'h00, 3'd5, 0};
    vecs[5]  = '{0, 1, 3'd0, 0, 1, 8'h01, 3'd0, 1};
    vecs[6]  = '{0, 1, 3'd7, 0, 1, 8'h80, 3'd7, 1};
    vecs[7]  = '{0, 1, 3'd3, 0, 1, 8'h08, 3'd3, 1};
    vecs[8]  = '{0, 1, 3'd1, 1, 0, 8'h00, 3'd3, 0};
    vecs[9]  = '{0, 0, 3'd0, 1, 0, 8'h00, 3'd3, 0};
    vecs[10] = '{1, 1, 3'd6, 0, 0, 8'h00, 3'd0, 0};
    vecs[11] = '{0, 0, 3'd0, 0, 1, 8'h00, 3'd0, 0};

    @(negedge clk);

    // ---------------- table-driven latch mode (d0) ----------------
    for (int i = 0; i < 12; i++) begin
      rst0 = vecs[i].rst; b0.iValid = vecs[i].valid; b0.iIn = vecs[i].in; b0.iClr = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(b0.oReady), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_out", i), 32'(b0.oOut), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_idx", i), 32'(b0.oIdx), 32'(vecs[i].exp_idx));
      chk($sformatf("vec%0d_act", i), 32'(b0.oActive), 32'(vecs[i].exp_act));
    end
    b0.iValid = 0; b0.iClr = 0;

    // ---------------- pulse length 4, iValid held (d1) ----------------
    rst1 = 1'b0;
    b1.iValid = 1; b1.iIn = 3'd2;
    #1 chk("p4_ready_first", 32'(b1.oReady), 32'd1);
    pat = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04};
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("p4_out_c%0d", i), 32'(b1.oOut), 32'(pat[i]));
      chk($sformatf("p4_ready_c%0d", i), 32'(b1.oReady), (pat[i] == 8'h00) ? 32'd1 : 32'd0);
      chk($sformatf("p4_act_c%0d", i), 32'(b1.oActive), (pat[i] == 8'h00) ? 32'd0 : 32'd1);
    end
    b1.iValid = 0;
    rst1 = 1'b1;

    // ---------------- pulse length 1 (d2) ----------------
    rst2 = 1'b0;
    b2.iValid = 1; b2.iIn = 3'd6;
    tick();
    b2.iValid = 0;
    #1;
    chk("p1_out_on", 32'(b2.oOut), 32'h40);
    chk("p1_ready_on", 32'(b2.oReady), 32'd0);
    tick();
    chk("p1_out_off", 32'(b2.oOut), 32'h00);
    chk("p1_ready_off", 32'(b2.oReady), 32'd1);
    chk("p1_idx_kept", 32'(b2.oIdx), 32'd6);

    // ---------------- pulse length 10: clear then reset mid-pulse (d3) ----
    rst3 = 1'b0;
    b3.iValid = 1; b3.iIn = 3'd4;
    tick();
    b3.iValid = 0;
    tick();
    b3.iClr = 1;
    #1 chk("p10_clr_ready", 32'(b3.oReady), 32'd0);
    tick();
    b3.iClr = 0;
    chk("p10_clr_out", 32'(b3.oOut), 32'h00);
    chk("p10_clr_act", 32'(b3.oActive), 32'd0);
    chk("p10_clr_idx", 32'(b3.oIdx), 32'd4);
    b3.iValid = 1; b3.iIn = 3'd3;
    tick();
    b3.iValid = 0;
    chk("p10_restart_out", 32'(b3.oOut), 32'h08);
    tick(); tick();
    rst3 = 1'b1;
    #1 chk("p10_rst_ready", 32'(b3.oReady), 32'd0);
    tick();
    chk("p10_rst_out", 32'(b3.oOut), 32'h00);
    chk("p10_rst_idx", 32'(b3.oIdx), 32'd0);
    chk("p10_rst_act", 32'(b3.oActive), 32'd0);
    rst3 = 1'b0;
    #1 chk("p10_post_rst_ready", 32'(b3.oReady), 32'd1);

    // ---------------- active-low, N=2 (d4) ----------------
    chk("al_reset_out", 32'(b4.oOut), 32'hF);
    rst4 = 1'b0;
    b4.iValid = 1; b4.iIn = 2'd1;
    tick();
    b4.iValid = 0;
    chk("al_out", 32'(b4.oOut), 32'hD);
    chk("al_act", 32'(b4.oActive), 32'd1);
    b4.iIn = 2'd3; b4.iValid = 1;
    tick();
    b4.iValid = 0;
    chk("al_msb_out", 32'(b4.oOut), 32'h7);
    b4.iClr = 1;
    tick();
    b4.iClr = 0;
    chk("al_clr_out", 32'(b4.oOut), 32'hF);
    chk("al_clr_idx", 32'(b4.oIdx), 32'd3);

    // ---------------- randomized: d0 and d1 vs. reference model ----------
    rst0 = 1'b1; rst1 = 1'b1;
    tick();
    m_len[0] = 0; m_len[1] = 4;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_idx[k] = 0; m_rem[k] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 31) == 0);
      cl = ($urandom_range(0, 7) == 0);
      v  = 1'($urandom_range(0, 1));
      x  = 3'($urandom_range(0, 7));
      rst0 = r; rst1 = r;
      b0.iValid = v; b0.iIn = x; b0.iClr = cl;
      b1.iValid = v; b1.iIn = x; b1.iClr = cl;
      #1;
      rd[0] = b0.oReady; rd[1] = b1.oReady;
      for (int k = 0; k < 2; k++) begin
        logic er;
        er = !r && !cl && !(m_len[k] != 0 && m_act[k]);
        chk($sformatf("rnd%0d_c%0d_ready", k, c), 32'(rd[k]), 32'(er));
        acc[k] = v && er;
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (r) begin
          m_act[k] = 0; m_idx[k] = 0; m_rem[k] = 0;
        end else if (cl) begin
          m_act[k] = 0; m_rem[k] = 0;
        end else if (acc[k]) begin
          m_act[k] = 1; m_idx[k] = int'(x); m_rem[k] = m_len[k];
        end else if (m_len[k] != 0 && m_act[k]) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) m_act[k] = 0;
        end
      end
      o[0] = b0.oOut; o[1] = b1.oOut;
      ix[0] = b0.oIdx; ix[1] = b1.oIdx;
      a[0] = b0.oActive; a[1] = b1.oActive;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d_c%0d_out", k, c), 32'(o[k]), m_act[k] ? (32'd1 << m_idx[k]) : 32'd0);
        chk($sformatf("rnd%0d_c%0d_idx", k, c), 32'(ix[k]), 32'(m_idx[k]));
        chk($sformatf("rnd%0d_c%0d_act", k, c), 32'(a[k]), 32'(m_act[k]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
